uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   Serial UART transmitter; the transmit-side companion of the 16x-oversampling receiver.
//   Accepts a parallel word on tx_start and frames it as start, data LSB-first, optional parity, stop.
//   Each bit is timed by the shared baud-rate tick (16 ticks per bit).
//   Sits between the host/FIFO write side and the tx pin.
// PARAMETERS
//   DATA_BITS   8   data bits per frame, legal 5..8
//   STOP_TICKS  16  ticks in stop phase: 16 = 1, 24 = 1.5, 32 = 2 stop bits
//   PARITY_EN   0   1 = insert parity bit after data
//   PARITY_ODD  0   when PARITY_EN: 0 = even parity, 1 = odd parity
// PORTS
//   clk       in   1          system clock; one clock domain, all logic on posedge clk
//   rst       in   1          synchronous, active-low reset
//   tick      in   1          baud tick, 1-clk pulse at 16x baud rate
//   tx_start  in   1          request to send din; sampled only in IDLE
//   din       in   DATA_BITS  word to send; latched on the accepting cycle
//   tx        out  1          serial line, registered, idles high
//   tx_busy   out  1          high from the cycle after accept until return to IDLE
//   tx_done   out  1          1-clk pulse when frame complete
// BEHAVIOUR
//   Interface: one clock; reset is synchronous and active-low.
//   Reset (rst==0 at posedge):
//     - state = IDLE; tick_cnt = 0; bit_cnt = 0; shift reg = 0; parity = 0.
//     - tx = 1; tx_busy = 0; tx_done = 0.
//     - Reset mid-frame aborts the frame; tx returns high on the next edge.
//   Counters:
//     - tick_cnt is 5 bits; bit_cnt is 3 bits.
//     - parity accumulates XOR of the shifted-out bits, then XORs PARITY_ODD.
//   IDLE:
//     - tx = 1.
//     - On tx_start: latch din into shift reg, tick_cnt = 0, go to START. tick is irrelevant here.
//     - tx drives low on the same edge (registered output), so latency is 1 clk from accept to tx low.
//   START:
//     - tx = 0; increment tick_cnt on tick.
//     - On tick with tick_cnt == 15: tick_cnt = 0, bit_cnt = 0, go to DATA.
//   DATA:
//     - tx = shift[0].
//     - On tick with tick_cnt == 15: shift right, bit_cnt++, tick_cnt = 0.
//     - If bit_cnt == DATA_BITS-1, go to PARITY when PARITY_EN, else STOP.
//   PARITY:
//     - tx = parity bit.
//     - On tick with tick_cnt == 15: tick_cnt = 0, go to STOP.
//   STOP:
//     - tx = 1.
//     - On tick with tick_cnt == STOP_TICKS-1: go to IDLE; tx_done = 1 for exactly that one clk.
//   Rules:
//     - tx_busy = (state != IDLE), registered.
//     - tx_start while not IDLE is ignored; din changes while busy have no effect.
//     - tx_start in the same cycle as the final stop tick is ignored (state is still STOP).
//       It is accepted if held into the following IDLE cycle.
//     - Without tick, all states hold; a frame lasts exactly (1 + DATA_BITS + PARITY_EN)*16 + STOP_TICKS ticks.
//     - Illegal state encoding goes to IDLE with tx = 1.
// TESTING
//   1. rst=0 for 3 clks, tx_start=1 -> tx=1, tx_busy=0, tx_done=0 throughout; no frame starts.
//   2. Defaults, din=8'hA5, tick every 4 clks -> tx low 16 ticks, then 1,0,1,0,0,1,0,1 at 16 ticks each;
//      then high 16 ticks; tx_done once after 160 ticks.
//   3. PARITY_EN=1, PARITY_ODD=0, din=8'h07 -> parity bit 1;
//      PARITY_ODD=1 gives 0; frame is 176 ticks.
//   4. tx_start pulsed mid-frame with din=8'hFF -> current 8'h3C frame unaltered; no second frame.
//   5. Hold tx_start=1 with din=8'h55 -> back-to-back frames;
//      IDLE lasts 1 clk between tx_done and the next start bit.
//   6. rst=0 during DATA bit 3 -> next edge tx=1, tx_busy=0, no tx_done;
//      a new frame after reset is bit-exact.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: frames din as start, DATA_BITS data LSB-first, optional parity, stop on tx.
// Latency: tx falls on the accept edge (1 clk after tx_start is sampled in IDLE); bit timing is 16 ticks.
// Backpressure: tx_start is only honoured in IDLE; requests while busy are dropped, so hold until !tx_busy.
//
// Ports: clk/rst (sync, active-low), tick (16x baud strobe), tx_start/din (send request),
//        tx (registered serial line, idles high), tx_busy (frame in flight), tx_done (1-clk end pulse).
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] din,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [4:0] LAST_TICK = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(STOP_TICKS - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);

    state_t               state, state_n;
    logic [4:0]           tick_cnt, tick_cnt_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 parity, parity_n;
    logic                 tx_n, busy_n, done_n;

    // State and datapath registers; outputs are registered from next-state values
    // so tx changes on the same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            parity   <= 1'b0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            parity   <= parity_n;
            tx       <= tx_n;
            tx_busy  <= busy_n;
            tx_done  <= done_n;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        parity_n   = parity;
        case (state)
            S_IDLE: begin
                if (tx_start) begin
                    state_n    = S_START;
                    shreg_n    = din;
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    parity_n   = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        bit_cnt_n  = '0;
                        state_n    = S_DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + 5'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        shreg_n    = shreg >> 1;
                        // parity is the running XOR of every bit shifted out
                        parity_n   = parity ^ shreg[0];
                        bit_cnt_n  = bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state_n = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 5'd1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        state_n    = S_STOP;
                    end else begin
                        tick_cnt_n = tick_cnt + 5'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tick_cnt_n = '0;
                        state_n    = S_IDLE;
                    end else begin
                        tick_cnt_n = tick_cnt + 5'd1;
                    end
                end
            end
            default: begin
                state_n    = S_IDLE;
                tick_cnt_n = '0;
                bit_cnt_n  = '0;
            end
        endcase
    end

    // Output decode from the state being entered.
    always_comb begin
        tx_n   = 1'b1;
        busy_n = (state_n != S_IDLE);
        done_n = (state == S_STOP) && (state_n == S_IDLE);
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = parity_n ^ PAR_ODD;
            default:  tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       tick_seen;
    logic [2:0] start_v;
    logic [7:0] din;
    logic [2:0] tx_v, busy_v, done_v;

    int assertions = 0;
    int failures   = 0;

    typedef struct {
        logic [11:0] bits;
        int          nticks;
    } frame_t;

    frame_t sb[$];

    always #5 clk = ~clk;

    // instance 0: 8N1, instance 1: 8E1, instance 2: 8O1
    uart_tx #(.DATA_BITS(8), .STOP_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start_v[0]), .din(din),
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx #(.DATA_BITS(8), .STOP_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start_v[1]), .din(din),
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx #(.DATA_BITS(8), .STOP_TICKS(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .tick(tick), .tx_start(start_v[2]), .din(din),
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    // baud tick: one clk high every 4 clks, changed on negedge
    initial begin
        tick = 1'b0;
        forever begin
            for (int p = 0; p < 4; p++) begin
                @(negedge clk);
                tick = (p == 3);
            end
        end
    end

    // tick value seen by the DUTs at the most recent posedge
    always @(posedge clk) tick_seen <= tick;

    function automatic frame_t make_frame(input logic [7:0] d, input bit pe, input bit odd);
        frame_t f;
        f.bits      = '1;
        f.bits[0]   = 1'b0;
        f.bits[8:1] = d;
        if (pe) f.bits[9] = (^d) ^ odd;
        f.nticks    = (10 + (pe ? 1 : 0)) * 16;
        return f;
    endfunction

    // Drive a one-clk tx_start on instance s and push the expected frame.
    task automatic send(input int s, input logic [7:0] d, input bit pe, input bit odd);
        @(negedge clk);
        din        = d;
        start_v[s] = 1'b1;
        sb.push_back(make_frame(d, pe, odd));
        @(negedge clk);
        start_v[s] = 1'b0;
    endtask

    // Record the line once per 16-tick bit slot from the start edge up to tx_done.
    // nbad counts samples where tx changed inside a slot or tx_busy was low mid-frame.
    task automatic capture(input int s, output logic [11:0] bits, output int nticks,
                           output int nbad, output bit ok);
        int  k;
        int  j;
        bit  low;
        bits   = '1;
        nticks = -1;
        nbad   = 0;
        ok     = 1'b0;
        k      = 0;
        low    = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (tx_v[s] === 1'b0) begin
                low = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!low) return;
        bits[0] = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done_v[s] === 1'b1) begin
                if (tick_seen === 1'b1) nticks = k + 1;
                ok = 1'b1;
                return;
            end
            if (busy_v[s] !== 1'b1) nbad++;
            if (tick_seen === 1'b1) k++;
            j = k / 16;
            if (j > 11) nbad++;
            else if (tick_seen === 1'b1 && (k % 16) == 0) bits[j] = tx_v[s];
            else if (tx_v[s] !== bits[j]) nbad++;
        end
    endtask

    task automatic test_reset;
        rst     = 1'b0;
        start_v = 3'b111;
        din     = 8'hA5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            assertions++;
            if (tx_v !== 3'b111) begin
                failures++;
                $display("FAIL reset_tx cycle %0d: got %b want 111", c, tx_v);
            end
            assertions++;
            if (busy_v !== 3'b000) begin
                failures++;
                $display("FAIL reset_busy cycle %0d: got %b want 000", c, busy_v);
            end
            assertions++;
            if (done_v !== 3'b000) begin
                failures++;
                $display("FAIL reset_done cycle %0d: got %b want 000", c, done_v);
            end
        end
        rst     = 1'b1;
        start_v = 3'b000;
        repeat (5) @(negedge clk);
        assertions++;
        if (busy_v !== 3'b000 || tx_v !== 3'b111) begin
            failures++;
            $display("FAIL reset_no_frame: busy %b tx %b want 000 111", busy_v, tx_v);
        end
    endtask

    task automatic test_basic;
        frame_t      e;
        logic [11:0] got;
        int          nt, nb, bad;
        bit          ok;
        send(0, 8'hA5, 1'b0, 1'b0);
        capture(0, got, nt, nb, ok);
        e = sb.pop_front();
        assertions++;
        if (!ok || got !== e.bits) begin
            failures++;
            $display("FAIL basic_bits: got %h (done %0b) want %h", got, ok, e.bits);
        end
        assertions++;
        if (nt != e.nticks) begin
            failures++;
            $display("FAIL basic_length: got %0d ticks want %0d", nt, e.nticks);
        end
        assertions++;
        if (nb != 0) begin
            failures++;
            $display("FAIL basic_bit_timing: %0d bad samples want 0", nb);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
        end
        assertions++;
        if (bad != 0) begin
            failures++;
            $display("FAIL basic_single_done: %0d bad idle cycles want 0", bad);
        end
    endtask

    task automatic test_parity;
        frame_t      e;
        logic [11:0] got;
        int          nt, nb;
        bit          ok;
        for (int s = 1; s <= 2; s++) begin
            send(s, 8'h07, 1'b1, (s == 2));
            capture(s, got, nt, nb, ok);
            e = sb.pop_front();
            assertions++;
            if (!ok || got !== e.bits) begin
                failures++;
                $display("FAIL parity_bits inst %0d: got %h (done %0b) want %h", s, got, ok, e.bits);
            end
            assertions++;
            if (nt != e.nticks || nb != 0) begin
                failures++;
                $display("FAIL parity_length inst %0d: got %0d ticks %0d bad want %0d ticks 0 bad",
                         s, nt, nb, e.nticks);
            end
        end
    endtask

    task automatic test_ignore_busy;
        frame_t      e;
        logic [11:0] got;
        int          nt, nb, bad;
        bit          ok;
        @(negedge clk);
        din        = 8'h3C;
        start_v[0] = 1'b1;
        sb.push_back(make_frame(8'h3C, 1'b0, 1'b0));
        @(negedge clk);
        start_v[0] = 1'b0;
        fork
            capture(0, got, nt, nb, ok);
            begin
                repeat (150) @(negedge clk);
                din        = 8'hFF;
                start_v[0] = 1'b1;
                @(negedge clk);
                start_v[0] = 1'b0;
            end
        join
        e = sb.pop_front();
        assertions++;
        if (!ok || got !== e.bits || nt != e.nticks || nb != 0) begin
            failures++;
            $display("FAIL busy_ignore_frame: got %h %0d ticks %0d bad want %h %0d ticks 0 bad",
                     got, nt, nb, e.bits, e.nticks);
        end
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad++;
        end
        assertions++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_ignore_no_second: %0d non-idle cycles want 0", bad);
        end
    endtask

    task automatic test_back_to_back;
        frame_t      e;
        logic [11:0] got;
        int          nt, nb;
        bit          ok;
        @(negedge clk);
        din        = 8'h55;
        start_v[0] = 1'b1;
        sb.push_back(make_frame(8'h55, 1'b0, 1'b0));
        sb.push_back(make_frame(8'h55, 1'b0, 1'b0));
        @(negedge clk);
        capture(0, got, nt, nb, ok);
        e = sb.pop_front();
        assertions++;
        if (!ok || got !== e.bits || nt != e.nticks || nb != 0) begin
            failures++;
            $display("FAIL b2b_first: got %h %0d ticks %0d bad want %h %0d ticks 0 bad",
                     got, nt, nb, e.bits, e.nticks);
        end
        // done cycle is the single IDLE cycle: line high, not busy
        assertions++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_gap: tx %b busy %b want 1 0", tx_v[0], busy_v[0]);
        end
        @(negedge clk);
        assertions++;
        if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: tx %b busy %b want 0 1", tx_v[0], busy_v[0]);
        end
        start_v[0] = 1'b0;
        capture(0, got, nt, nb, ok);
        e = sb.pop_front();
        assertions++;
        if (!ok || got !== e.bits || nt != e.nticks || nb != 0) begin
            failures++;
            $display("FAIL b2b_second: got %h %0d ticks %0d bad want %h %0d ticks 0 bad",
                     got, nt, nb, e.bits, e.nticks);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame;
        frame_t      e;
        logic [11:0] got;
        logic [7:0]  d;
        int          nt, nb, k, bad;
        bit          ok;
        d = 8'hC3;
        @(negedge clk);
        din        = d;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        k = 0;
        for (int c = 0; c < 1000 && k < 72; c++) begin
            @(negedge clk);
            if (tick_seen === 1'b1) k++;
        end
        // 72 ticks in: middle of data bit 3
        assertions++;
        if (k != 72 || tx_v[0] !== d[3] || busy_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_bit3: ticks %0d tx %b busy %b want 72 %b 1", k, tx_v[0], busy_v[0], d[3]);
        end
        rst = 1'b0;
        @(negedge clk);
        assertions++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL midreset_abort: tx %b busy %b done %b want 1 0 0", tx_v[0], busy_v[0], done_v[0]);
        end
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad++;
        end
        assertions++;
        if (bad != 0) begin
            failures++;
            $display("FAIL midreset_quiet: %0d non-idle cycles want 0", bad);
        end
        send(0, 8'h96, 1'b0, 1'b0);
        capture(0, got, nt, nb, ok);
        e = sb.pop_front();
        assertions++;
        if (!ok || got !== e.bits || nt != e.nticks || nb != 0) begin
            failures++;
            $display("FAIL midreset_next_frame: got %h %0d ticks %0d bad want %h %0d ticks 0 bad",
                     got, nt, nb, e.bits, e.nticks);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        assertions++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d frames left want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
